// File: rtl/mc_ctrl_unit.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder, NZCV flag file
// and condition evaluation that gates every architectural write.
module mc_ctrl_unit #(
  parameter bit         EXT_OPS    = 1'b1,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_ORR   = 3'b011,
    ALU_EOR   = 3'b100,
    ALU_PASSB = 3'b101
  } alu_ctrl_t;

  typedef struct packed {
    logic       irw;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
  } ctrl_t;

  state_t    state_q, state_d, out_state;
  ctrl_t     ctrl;
  alu_ctrl_t alu_ctrl;
  logic      nowrite, arith, force_s;
  logic [1:0] flag_w;
  logic      cond_ex, cond_ex_q;
  logic [3:0] flags_q;
  logic      pcs;
  logic      fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = nowrite ? S_FETCH : S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // While reset is asserted the selects present the FETCH setting.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    ctrl = '0;
    case (out_state)
      S_FETCH: begin
        ctrl.irw       = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.alusrca   = 2'b01;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
      end
      S_DECODE: begin
        ctrl.alusrca   = 2'b01;
        ctrl.alusrcb   = 2'b10;
        ctrl.resultsrc = 2'b10;
      end
      S_MEMADR: ctrl.alusrcb = 2'b01;
      S_MEMRD:  ctrl.adrsrc  = 1'b1;
      S_MEMWB: begin
        ctrl.resultsrc = 2'b01;
        ctrl.regw      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adrsrc = 1'b1;
        ctrl.memw   = 1'b1;
      end
      S_EXECR:  ctrl.aluop = 1'b1;
      S_EXECI: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = 1'b1;
      end
      S_ALUWB:  ctrl.regw = 1'b1;
      S_BRANCH: begin
        ctrl.alusrca   = 2'b10;
        ctrl.alusrcb   = 2'b01;
        ctrl.resultsrc = 2'b10;
        ctrl.branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode; compare/test forms suppress writeback but always set flags.
  always_comb begin
    alu_ctrl = ALU_ADD;
    nowrite  = 1'b0;
    arith    = 1'b1;
    force_s  = 1'b0;
    if (ctrl.aluop) begin
      case (Funct[4:1])
        4'b0100: alu_ctrl = ALU_ADD;
        4'b0010: alu_ctrl = ALU_SUB;
        4'b0000: begin alu_ctrl = ALU_AND; arith = 1'b0; end
        4'b1100: begin alu_ctrl = ALU_ORR; arith = 1'b0; end
        default: begin
          if (EXT_OPS) begin
            case (Funct[4:1])
              4'b0001: begin alu_ctrl = ALU_EOR;   arith = 1'b0; end
              4'b1101: begin alu_ctrl = ALU_PASSB; arith = 1'b0; end
              4'b1010: begin alu_ctrl = ALU_SUB; nowrite = 1'b1; force_s = 1'b1; end
              4'b1011: begin alu_ctrl = ALU_ADD; nowrite = 1'b1; force_s = 1'b1; end
              4'b1000: begin
                alu_ctrl = ALU_AND;
                nowrite  = 1'b1;
                force_s  = 1'b1;
                arith    = 1'b0;
              end
              default: alu_ctrl = ALU_ADD;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    flag_w = 2'b00;
    if (ctrl.aluop && (Funct[0] || force_s)) flag_w = {1'b1, arith};
  end

  always_comb begin
    case (Cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~fc | fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = fz | (fn != fv);
      default: cond_ex = 1'b1;
    endcase
  end

  // Condition is captured once per instruction, against the flags it saw at decode.
  always_ff @(posedge clk) begin
    if (reset)                   cond_ex_q <= 1'b1;
    else if (state_q == S_DECODE) cond_ex_q <= cond_ex;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RESET;
    end else begin
      if (flag_w[1] && cond_ex_q) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w[0] && cond_ex_q) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcs = ((Rd == 4'd15) & ctrl.regw) | ctrl.branch;

  assign PCWrite    = ~reset & (ctrl.nextpc | (pcs & cond_ex_q));
  assign RegWrite   = ~reset & ctrl.regw & cond_ex_q;
  assign MemWrite   = ~reset & ctrl.memw & cond_ex_q;
  assign IRWrite    = ~reset & ctrl.irw;
  assign AdrSrc     = ctrl.adrsrc;
  assign ResultSrc  = ctrl.resultsrc;
  assign ALUSrcA    = ctrl.alusrca;
  assign ALUSrcB    = ctrl.alusrcb;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign ALUControl = alu_ctrl;
  assign Flags      = flags_q;
  assign State      = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: two instances (EXT_OPS=0/1), one
// exercised at a time, checked every cycle against an instruction-level model.
module tb_mc_ctrl_unit;

  logic       clk;
  logic       rst [2];
  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;

  logic       pcw [2], adrs [2], memw [2], irw [2], regw [2];
  logic [1:0] rsrc [2], asrca [2], asrcb [2], imms [2], regs [2];
  logic [2:0] aluc [2];
  logic [3:0] flags_o [2], state_o [2];

  logic [3:0] m_flags [2];
  int n_cmp = 0;
  int n_bad = 0;

  mc_ctrl_unit #(.EXT_OPS(1'b0), .FLAG_RESET(4'b1010)) u_base (
    .clk(clk), .reset(rst[0]), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd),
    .ALUFlags(alu_flags), .PCWrite(pcw[0]), .AdrSrc(adrs[0]), .MemWrite(memw[0]),
    .IRWrite(irw[0]), .RegWrite(regw[0]), .ResultSrc(rsrc[0]), .ALUSrcA(asrca[0]),
    .ALUSrcB(asrcb[0]), .ImmSrc(imms[0]), .RegSrc(regs[0]), .ALUControl(aluc[0]),
    .Flags(flags_o[0]), .State(state_o[0])
  );

  mc_ctrl_unit #(.EXT_OPS(1'b1), .FLAG_RESET(4'b0000)) u_ext (
    .clk(clk), .reset(rst[1]), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd),
    .ALUFlags(alu_flags), .PCWrite(pcw[1]), .AdrSrc(adrs[1]), .MemWrite(memw[1]),
    .IRWrite(irw[1]), .RegWrite(regw[1]), .ResultSrc(rsrc[1]), .ALUSrcA(asrca[1]),
    .ALUSrcB(asrcb[1]), .ImmSrc(imms[1]), .RegSrc(regs[1]), .ALUControl(aluc[1]),
    .Flags(flags_o[1]), .State(state_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] flag_reset_of(input int k);
    return (k == 1) ? 4'b0000 : 4'b1010;
  endfunction

  // ARM condition semantics on an {N,Z,C,V} value.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;              1: return !z;
      2: return cy;             3: return !cy;
      4: return n;              5: return !n;
      6: return v;              7: return !v;
      8: return cy && !z;       9: return !cy || z;
      10: return n == v;        11: return n != v;
      12: return !z && n == v;  13: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction

  // Data-processing meaning of a command: ALU op, writeback suppression,
  // whether C/V are architecturally updated, and whether flags are set regardless of S.
  task automatic dp_info(input bit ext, input logic [3:0] cmd, output logic [2:0] ctl,
                         output logic nw, output logic ar, output logic fs);
    ctl = 3'b000; nw = 0; ar = 1; fs = 0;
    if (cmd == 4'b0010) ctl = 3'b001;
    else if (cmd == 4'b0000) begin ctl = 3'b010; ar = 0; end
    else if (cmd == 4'b1100) begin ctl = 3'b011; ar = 0; end
    else if (ext) begin
      if (cmd == 4'b0001) begin ctl = 3'b100; ar = 0; end
      else if (cmd == 4'b1101) begin ctl = 3'b101; ar = 0; end
      else if (cmd == 4'b1010) begin ctl = 3'b001; nw = 1; fs = 1; end
      else if (cmd == 4'b1011) begin nw = 1; fs = 1; end
      else if (cmd == 4'b1000) begin ctl = 3'b010; nw = 1; fs = 1; ar = 0; end
    end
  endtask

  // {ResultSrc, ALUSrcA, ALUSrcB} expected in each state.
  function automatic logic [5:0] sel_of(input int s);
    case (s)
      0, 1:    return 6'b10_01_10;
      2, 7:    return 6'b00_00_01;
      4:       return 6'b01_00_00;
      9:       return 6'b10_10_01;
      default: return 6'b00_00_00;
    endcase
  endfunction

  task automatic do_reset(input int k, input int cycles);
    rst[k] = 1'b1;
    rst[1-k] = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pcw[k], irw[k], regw[k], memw[k], rsrc[k], asrca[k], asrcb[k]} !== 10'b0000_100110) begin
        n_bad++;
        $display("FAIL reset_outputs inst=%0d: got en=%b sel=%b, required en=0000 sel=100110",
                 k, {pcw[k], irw[k], regw[k], memw[k]}, {rsrc[k], asrca[k], asrcb[k]});
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (state_o[k] !== 4'd0 || flags_o[k] !== flag_reset_of(k)) begin
      n_bad++;
      $display("FAIL reset_state inst=%0d: got state=%0d flags=%b, required state=0 flags=%b",
               k, state_o[k], flags_o[k], flag_reset_of(k));
    end
    rst[k] = 1'b0;
    m_flags[k] = flag_reset_of(k);
  endtask

  // Drive one instruction from FETCH to its last state, checking every cycle.
  task automatic run_instr(input int k, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
    int seq[$];
    logic pass, nw, ar, fs, e_pcw, e_regw, e_memw, e_irw, e_adr;
    logic [2:0] ctl, e_ctl;
    logic [25:0] exp_v, obs_v;
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
    pass = cond_ok(c, m_flags[k]);
    dp_info(k == 1, f[4:1], ctl, nw, ar, fs);
    seq.push_back(0);
    seq.push_back(1);
    case (o)
      2'b01: begin
        seq.push_back(2);
        if (f[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b00: begin
        seq.push_back(f[5] ? 7 : 6);
        if (!nw) seq.push_back(8);
      end
      2'b10:   seq.push_back(9);
      default: seq.push_back(10);
    endcase
    foreach (seq[i]) begin
      int s;
      s = seq[i];
      @(negedge clk);
      e_irw  = (s == 0);
      e_pcw  = (s == 0) || (pass && (s == 9 || ((s == 4 || s == 8) && r == 4'd15)));
      e_regw = pass && (s == 4 || s == 8);
      e_memw = pass && (s == 5);
      e_adr  = (s == 3 || s == 5);
      e_ctl  = (s == 6 || s == 7) ? ctl : 3'b000;
      exp_v = {4'(s), e_pcw, e_regw, e_memw, e_irw, e_adr, e_ctl, m_flags[k], sel_of(s),
               o, o == 2'b01, o == 2'b10};
      obs_v = {state_o[k], pcw[k], regw[k], memw[k], irw[k], adrs[k], aluc[k], flags_o[k],
               rsrc[k], asrca[k], asrcb[k], imms[k], regs[k]};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle inst=%0d cond=%b op=%b funct=%b rd=%0d: got state=%0d vec=%b, required state=%0d vec=%b",
                 k, c, o, f, r, state_o[k], obs_v, s, exp_v);
      end
      @(posedge clk); #1;
      if ((s == 6 || s == 7) && pass && (f[0] || fs)) begin
        m_flags[k][3:2] = af[3:2];
        if (ar) m_flags[k][1:0] = af[1:0];
      end
    end
  endtask

  task automatic test_reset();
    do_reset(1, 2);
  endtask

  task automatic test_ldr();
    run_instr(1, 4'b1110, 2'b01, 6'b011001, 4'd3, 4'($urandom));
  endtask

  task automatic test_subs_beq();
    run_instr(1, 4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0100);
    run_instr(1, 4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
  endtask

  task automatic test_bne();
    run_instr(1, 4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run_instr(1, 4'b1110, 2'b01, 6'b011000, 4'd5, 4'b0000);
  endtask

  task automatic test_cmp();
    run_instr(1, 4'b1110, 2'b00, 6'b010101, 4'd4, 4'b1001);
    do_reset(0, 1);
    run_instr(0, 4'b1110, 2'b00, 6'b010101, 4'd4, 4'b0110);
  endtask

  task automatic test_rd15();
    run_instr(0, 4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
    run_instr(0, 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
  endtask

  task automatic test_reset_mid();
    do_reset(1, 1);
    run_instr(1, 4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0100);
    cond = 4'b1110; op = 2'b01; funct = 6'b011000; rd = 4'd6;
    repeat (3) @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state_o[1] !== 4'd5 || memw[1] !== 1'b0 || flags_o[1] !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_in_memwr: got state=%0d memwrite=%b flags=%b, required state=5 memwrite=0 flags=0100",
               state_o[1], memw[1], flags_o[1]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (state_o[1] !== 4'd0 || flags_o[1] !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_after_memwr: got state=%0d flags=%b, required state=0 flags=0000",
               state_o[1], flags_o[1]);
    end
    rst[1] = 1'b0;
    m_flags[1] = flag_reset_of(1);
    run_instr(1, 4'b1110, 2'b10, 6'b000000, 4'd0, 4'b0000);
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      do_reset(k, 1);
      for (int n = 0; n < 80; n++) begin
        run_instr(k, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom), 4'($urandom));
      end
    end
  endtask

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    cond = '0; op = '0; funct = '0; rd = '0; alu_flags = '0;
    m_flags[0] = flag_reset_of(0);
    m_flags[1] = flag_reset_of(1);
    test_reset();
    test_ldr();
    test_subs_beq();
    test_bne();
    test_cmp();
    test_rd15();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_unit.md
Name: mc_ctrl_unit

Overview:
- Parametrised multicycle ARM-subset control unit, successor to the current decoder. Sits between the instruction register and the multicycle datapath.
- Holds the main control FSM, the ALU decoder with optional extended data-processing ops, and a registered NZCV flag file.
- Evaluates all 16 ARM conditions and uses the result to gate every architectural write, including the PC.

Parameters:
EXT_OPS, 1, 1 enables EOR/MOV/CMP/CMN/TST decode; 0 limits decode to ADD/SUB/AND/ORR
FLAG_RESET, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
Cond  in  4  instruction condition field Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  destination register
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC enable
AdrSrc  out  1  memory address select (0 PC, 1 ALUOut)
MemWrite  out  1  data memory write
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write
ResultSrc  out  2  result mux select
ALUSrcA  out  2  ALU A select
ALUSrcB  out  2  ALU B select
ImmSrc  out  2  extend control (=Op)
RegSrc  out  2  {Op==01, Op==10}
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 pass-B
Flags  out  4  registered NZCV
State  out  4  FSM state code (debug)

Behaviour:
- Single clock domain `clk`. All state changes on the rising edge. `reset` is synchronous and active-high.
- Reset effects: State=FETCH(0), Flags=FLAG_RESET, CondExR=1.
- While reset is high: PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Mux selects show FETCH values.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, UNKNOWN 10.
- Transitions:
  - FETCH → DECODE.
  - DECODE on Op:
    - Op=01 → MEMADR.
    - Op=00 with Funct[5]=0 → EXECR.
    - Op=00 with Funct[5]=1 → EXECI.
    - Op=10 → BRANCH.
    - Op=11 → UNKNOWN.
  - MEMADR → MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECR/EXECI → ALUWB, or → FETCH directly when NoWrite=1.
  - ALUWB, BRANCH and UNKNOWN → FETCH. UNKNOWN has no writes (NOP).
- Moore raw outputs (any signal not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 → ADD.
  - ALUOp=1, decoded on Funct[4:1]:
    - 0100 ADD.
    - 0010 SUB.
    - 0000 AND.
    - 1100 ORR.
    - If EXT_OPS=1: 0001 EOR, 1101 pass-B, 1010 SUB+NoWrite, 1011 ADD+NoWrite, 1000 AND+NoWrite.
    - Any other command → ADD, NoWrite=0.
- FlagW (only when ALUOp=1 and Funct[0]=1):
  - FlagW[1] (NZ) = 1.
  - FlagW[0] (CV) = 1 only for arithmetic ops (ADD/SUB/CMP/CMN).
  - CMP/CMN/TST force FlagW as if S=1.
- Condition logic:
  - CondEx is combinational on Cond and the registered Flags, full ARM table: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. Cond=1111 → CondEx=1.
  - CondExR is loaded from CondEx only in the cycle State=DECODE. It holds the value for the rest of the instruction.
- Gating:
  - PCS = ((Rd==15) & RegW) | Branch.
  - PCWrite = NextPC | (PCS & CondExR).
  - RegWrite = RegW & CondExR.
  - MemWrite = MemW & CondExR.
- Flag update:
  - Flags[3:2] ← ALUFlags[3:2] when in EXECR/EXECI and FlagW[1] & CondExR.
  - Flags[1:0] ← ALUFlags[1:0] when in EXECR/EXECI and FlagW[0] & CondExR.
  - Flags written in cycle N are visible to the next instruction's DECODE.
- Reset mid-instruction: the next cycle is FETCH. No partial write occurs, because the write enables are held 0 while reset is high.

Test Plan:
- Reset then LDR (Op=01, Funct[0]=1, Cond=1110): State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4. IRWrite=1 only in state 0.
- SUBS EXECR (Funct=000101, ALUFlags=0100): ALUControl=001. Flags=0100 after EXECR. Following BEQ (Op=10, Cond=0000) gives PCWrite=1 in BRANCH.
- BNE after Flags=0100 (Op=10, Cond=0001): CondExR=0. PCWrite=0 in BRANCH, PCWrite=1 in next FETCH.
- CMP with EXT_OPS=1 (Funct=010101): ALUControl=001. EXECR → FETCH without ALUWB. RegWrite stays 0.
- Same CMP encoding with EXT_OPS=0: ALUControl=000, passes through ALUWB, RegWrite=1.
- Data-processing with Rd=15, AL: PCWrite=1 in ALUWB. Assert reset during MEMWR: MemWrite=0, State=0 next cycle, Flags=FLAG_RESET.
